e_muldiv: RTL and testbench

- Multiply/divide unit in the Execute stage, directly downstream of the D/E pipeline register.
- Consumes the E-stage operands (rs, rt values) and a decoded mul/div op, and owns the HI/LO registers.
- Models multi-cycle latency with a busy counter, so the hazard unit can stall D while an operation is in flight.
- Provides MFHI/MFLO read data to the E-stage result mux.

---
 rtl/e_muldiv.sv | 126 ++++++++++++
 tb/tb_e_muldiv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv.sv
// rtl/e_muldiv.sv - E-stage multiply/divide unit owning HI/LO, with a busy counter that models multi-cycle latency.
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        E_md_busy,
  output logic        E_md_start,
  output logic        E_md_stall_req,
  output logic [31:0] E_md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_temp_hi;
  logic [31:0] r_temp_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_mul       = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
  assign w_is_div       = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
  assign E_md_start     = (w_is_mul || w_is_div) && !r_busy;
  assign E_md_busy      = r_busy;
  assign E_md_stall_req = E_md_start || r_busy;
  assign HI             = r_hi;
  assign LO             = r_lo;

  assign w_prod_s = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign w_prod_u = {32'b0, E_rs} * {32'b0, E_rt};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  assign w_abs_a = E_rs[31] ? (~E_rs + 32'd1) : E_rs;
  assign w_abs_b = E_rt[31] ? (~E_rt + 32'd1) : E_rt;
  assign w_sq    = w_abs_a / w_abs_b;
  assign w_sr    = w_abs_a % w_abs_b;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (E_md_op)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        if (E_rt != 32'd0) begin
          w_res_lo = (E_rs[31] ^ E_rt[31]) ? (~w_sq + 32'd1) : w_sq;
          w_res_hi = E_rs[31] ? (~w_sr + 32'd1) : w_sr;
        end
      end
      OP_DIVU: begin
        if (E_rt != 32'd0) begin
          w_res_lo = E_rs / E_rt;
          w_res_hi = E_rs % E_rt;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    E_md_out = 32'd0;
    if (E_md_op == OP_MFHI) E_md_out = r_hi;
    else if (E_md_op == OP_MFLO) E_md_out = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= 4'd0;
      r_temp_hi <= 32'd0;
      r_temp_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else if (E_md_start) begin
      r_temp_hi <= w_res_hi;
      r_temp_lo <= w_res_lo;
      r_cnt     <= w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == 4'd1) begin
        r_hi   <= r_temp_hi;
        r_lo   <= r_temp_lo;
        r_busy <= 1'b0;
        r_cnt  <= 4'd0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (E_md_op == OP_MTHI) begin
      r_hi <= E_rs;
    end else if (E_md_op == OP_MTLO) begin
      r_lo <= E_rs;
    end
  end

endmodule

// File: tb/tb_e_muldiv.sv
// tb/tb_e_muldiv.sv - self-checking bench for e_muldiv against a plain-arithmetic HI/LO model.
module tb_e_muldiv;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        E_md_busy;
  logic        E_md_start;
  logic        E_md_stall_req;
  logic [31:0] E_md_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_rs(E_rs), .E_rt(E_rt),
    .E_md_busy(E_md_busy), .E_md_start(E_md_start), .E_md_stall_req(E_md_stall_req),
    .E_md_out(E_md_out), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of an accepted op, from the arithmetic rules alone.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] p;
    case (op)
      4'd1: begin
        p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd2: begin
        p = 64'(rs) * 64'(rt);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd3: if (rt != 0) begin
        a = longint'($signed(rs)); b = longint'($signed(rt));
        q = a / b; r = a % b;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      4'd4: if (rt != 0) begin
        m_lo = rs / rt; m_hi = rs % rt;
      end
      4'd5: m_hi = rs;
      4'd6: m_lo = rs;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    bit md;
    md = (op >= 4'd1 && op <= 4'd4);
    @(negedge clk);
    E_md_op = op; E_rs = rs; E_rt = rt;
    #1;
    check("start", E_md_start, md);
    check("stall_req", E_md_stall_req, md);
    check("md_out", E_md_out, op == 4'd7 ? m_hi : (op == 4'd8 ? m_lo : 32'd0));
    @(posedge clk); #1;
    E_md_op = 4'd0;
    n = 0;
    while (E_md_busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_len", n, md ? ((op <= 4'd2) ? MC : DC) : 0);
    model_apply(op, rs, rt);
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] rs, rt;
    int n;
    reset = 1'b1; E_md_op = 4'd0; E_rs = 32'd0; E_rt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", E_md_busy, 0);
    check("rst_HI", HI, 0);
    check("rst_LO", LO, 0);
    reset = 1'b0;

    // Directed cases
    run_op(4'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_hi_const", HI, 32'hFFFFFFFF);
    check("mult_lo_const", LO, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3);
    check("multu_hi_const", HI, 32'h00000002);
    run_op(4'd8, 32'd0, 32'd0);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo_const", LO, 32'hFFFFFFFD);
    check("div_hi_const", HI, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd2);
    check("divu_lo_const", LO, 32'd3);
    check("divu_hi_const", HI, 32'd1);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo_const", LO, 32'h80000000);
    check("ovf_hi_const", HI, 32'd0);
    run_op(4'd5, 32'h1234, 32'd0);
    run_op(4'd6, 32'h5678, 32'd0);
    run_op(4'd3, 32'd99, 32'd0);
    check("dz_hi_const", HI, 32'h1234);
    check("dz_lo_const", LO, 32'h5678);
    run_op(4'd4, 32'd99, 32'd0);

    // Ops presented while a DIV is in flight are stalled, not accepted
    @(negedge clk);
    E_md_op = 4'd3; E_rs = 32'd100; E_rt = 32'd7;
    @(posedge clk); #1;
    model_apply(4'd3, 32'd100, 32'd7);
    E_md_op = 4'd1; E_rs = 32'd5; E_rt = 32'd6;
    #1;
    check("busy_mult_start", E_md_start, 0);
    check("busy_mult_stall", E_md_stall_req, 1);
    @(posedge clk); #1;
    E_md_op = 4'd5; E_rs = 32'hDEAD;
    #1;
    check("busy_mthi_stall", E_md_stall_req, 1);
    @(posedge clk); #1;
    E_md_op = 4'd0;
    n = 0;
    while (E_md_busy && n < 40) begin n++; @(posedge clk); #1; end
    check("busy_rem_len", n, DC - 2);
    check("busy_HI", HI, m_hi);
    check("busy_LO", LO, m_lo);

    // Reset in the third busy cycle of a MULT cancels the pending commit
    @(negedge clk);
    E_md_op = 4'd1; E_rs = 32'd9; E_rt = 32'd9;
    @(posedge clk); #1;
    E_md_op = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", E_md_busy, 0);
    check("mid_rst_HI", HI, 0);
    check("mid_rst_LO", LO, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (MC + 2) @(posedge clk);
    #1;
    check("no_late_HI", HI, 0);
    check("no_late_LO", LO, 0);
    check("no_late_busy", E_md_busy, 0);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'hFFFFFFFF;
        2: rs = 32'h80000000;
        default: ;
      endcase
      run_op(op, rs, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
